// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and types for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int unsigned FETCH_DEPTH       = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry FIFO with flush, holds fetched words and address tags
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Next state: flush wins; a pop frees the slot a same-cycle push may take when full.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & (count_q != 2'd0);
    do_push  = push_i & ((count_q != 2'd2) | do_pop);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, request budget, redirect flush, F register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        PC_stall_i,
  input  logic        PC_bubble_i,
  input  logic        F_stall_i,
  input  logic        F_bubble_i,
  input  logic        E_jmp_sel_i,
  input  logic [31:0] E_jmp_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] F_pc_o,
  output logic [31:0] F_instr_o,
  output logic        F_valid_o,
  output logic        F_wait_o
);

  localparam logic [2:0] DEPTH = 3'(FETCH_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   discard_q, discard_d;
  logic [31:0]  f_pc_q, f_pc_d;
  logic [31:0]  f_instr_q, f_instr_d;
  logic         f_valid_q, f_valid_d;

  logic [2:0]   in_flight;
  logic         issue, rvalid_ok, rsp_keep, rsp_drop;
  logic         fifo_push, fifo_pop, fifo_empty;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  logic [31:0]  tag_head;
  logic [1:0]   tag_count;
  logic         tag_empty;

  // Request gating, response accounting, PC and the RUN/FLUSH controller.
  always_comb begin
    in_flight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req_o = (state_q == ST_RUN) & ~E_jmp_sel_i & ~PC_stall_i & ~PC_bubble_i
                 & (in_flight < DEPTH);
    issue      = imem_req_o & imem_gnt_i;
    rvalid_ok  = imem_rvalid_i & (outstanding_q != 2'd0);
    rsp_keep   = rvalid_ok & (discard_q == 2'd0);
    rsp_drop   = rvalid_ok & (discard_q != 2'd0);
    fifo_push  = rsp_keep & ~E_jmp_sel_i;
    fifo_pop   = ~F_stall_i & ~E_jmp_sel_i & ~F_bubble_i & ~fifo_empty;

    outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, rvalid_ok};
    discard_d     = discard_q - {1'b0, rsp_drop};
    pc_d          = issue ? pc_q + 32'd4 : pc_q;
    state_d       = state_q;
    if (E_jmp_sel_i) begin
      // Everything still in flight belongs to the wrong path.
      pc_d      = E_jmp_target_i;
      discard_d = outstanding_d;
      state_d   = (outstanding_d != 2'd0) ? ST_FLUSH : ST_RUN;
    end else if ((state_q == ST_FLUSH) && (discard_d == 2'd0)) begin
      state_d = ST_RUN;
    end
  end

  // F output register next value, stall > redirect/bubble > FIFO head > NOP.
  always_comb begin
    f_pc_d    = f_pc_q;
    f_instr_d = f_instr_q;
    f_valid_d = f_valid_q;
    if (!F_stall_i) begin
      if (E_jmp_sel_i || F_bubble_i || fifo_empty) begin
        f_pc_d    = 32'd0;
        f_instr_d = NOP_INSTR;
        f_valid_d = 1'b0;
      end else begin
        f_pc_d    = fifo_head.pc;
        f_instr_d = fifo_head.instr;
        f_valid_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // F output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f_pc_q    <= 32'd0;
      f_instr_q <= NOP_INSTR;
      f_valid_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      f_instr_q <= f_instr_d;
      f_valid_q <= f_valid_d;
    end
  end

  fetch_fifo #(.W(32)) u_tag_q (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (E_jmp_sel_i),
    .push_i      (issue),
    .push_data_i (pc_q),
    .pop_i       (rsp_keep),
    .head_o      (tag_head),
    .count_o     (tag_count),
    .empty_o     (tag_empty)
  );

  fetch_fifo #(.W(64)) u_instr_q (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (E_jmp_sel_i),
    .push_i      (fifo_push),
    .push_data_i ({tag_head, imem_rdata_i}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign imem_addr_o = pc_q;
  assign F_pc_o      = f_pc_q;
  assign F_instr_o   = f_instr_q;
  assign F_valid_o   = f_valid_q;
  assign F_wait_o    = ~F_stall_i & ~E_jmp_sel_i & ~F_bubble_i & fifo_empty;

  // A response with nothing in flight is ignored by the logic but flagged here.
  a_no_lost_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_rvalid_i |-> (outstanding_q != 2'd0));
  a_budget: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    in_flight <= DEPTH);
  a_tags_track: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    tag_count == (outstanding_q - discard_q));
  a_tag_present: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rsp_keep |-> !tag_empty);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        PC_stall_i = 1'b0;
  logic        PC_bubble_i = 1'b0;
  logic        F_stall_i = 1'b0;
  logic        F_bubble_i = 1'b0;
  logic        E_jmp_sel_i = 1'b0;
  logic [31:0] E_jmp_target_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] F_pc_o;
  logic [31:0] F_instr_o;
  logic        F_valid_o;
  logic        F_wait_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .PC_stall_i     (PC_stall_i),
    .PC_bubble_i    (PC_bubble_i),
    .F_stall_i      (F_stall_i),
    .F_bubble_i     (F_bubble_i),
    .E_jmp_sel_i    (E_jmp_sel_i),
    .E_jmp_target_i (E_jmp_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .F_pc_o         (F_pc_o),
    .F_instr_o      (F_instr_o),
    .F_valid_o      (F_valid_o),
    .F_wait_o       (F_wait_o)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_logged = 0;
  logic [31:0] mq[$];
  logic        mem_hold = 1'b0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] exp_pc = RST_PC;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: memory answers oldest request unless held; F loads are checked in order.
  task automatic tick();
    logic stalled;
    imem_rvalid_i = (mq.size() != 0) && !mem_hold;
    imem_rdata_i  = imem_rvalid_i ? word_at(mq[0]) : 32'hDEAD_BEEF;
    #1;
    last_req  = imem_req_o;
    last_addr = imem_addr_o;
    stalled   = F_stall_i;
    if (imem_rvalid_i) void'(mq.pop_front());
    if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
    @(posedge clk_i);
    #1;
    if (!stalled && F_valid_o) begin
      check("f_pc_seq", F_pc_o, exp_pc);
      check("f_instr_seq", F_instr_o, word_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_logged++;
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = last_req;
    end
    check(tag, seen ? last_addr : 32'hBAD0_BAD0, exp_addr);
  endtask

  initial begin
    int base;
    logic [31:0] pc0, instr0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_f_valid", 32'(F_valid_o), 32'd0);
    check("rst_f_pc", F_pc_o, 32'd0);
    check("rst_f_instr", F_instr_o, NOP);
    check("rst_addr", imem_addr_o, RST_PC);
    check("rst_f_wait", 32'(F_wait_o), 32'd1);

    rst_n_i = 1'b1;
    #1;
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, RST_PC);

    // Free-running fetch from reset.
    repeat (12) tick();
    check("seq_progress", 32'(n_logged >= 6), 32'd1);

    // Decode stalls for three cycles; budget saturates and F holds.
    F_stall_i = 1'b1;
    pc0 = F_pc_o;
    instr0 = F_instr_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", F_pc_o, pc0);
      check("stall_hold_instr", F_instr_o, instr0);
    end
    check("stall_no_req", 32'(last_req), 32'd0);
    F_stall_i = 1'b0;
    base = n_logged;
    repeat (8) tick();
    check("stall_release_progress", 32'(n_logged - base >= 4), 32'd1);

    // Two requests outstanding, then redirect to 0x100.
    mem_hold = 1'b1;
    repeat (4) tick();
    check("hold_outstanding", 32'(mq.size()), 32'd2);
    check("hold_wait", 32'(F_wait_o), 32'd1);
    E_jmp_sel_i = 1'b1;
    E_jmp_target_i = 32'h0000_0100;
    tick();
    check("jmp_req_low", 32'(last_req), 32'd0);
    check("jmp_f_valid", 32'(F_valid_o), 32'd0);
    check("jmp_f_instr", F_instr_o, NOP);
    E_jmp_sel_i = 1'b0;
    mem_hold = 1'b0;
    exp_pc = 32'h0000_0100;
    tick();
    check("flush1_req", 32'(last_req), 32'd0);
    tick();
    check("flush2_req", 32'(last_req), 32'd0);
    tick();
    check("post_flush_req", 32'(last_req), 32'd1);
    check("post_flush_addr", last_addr, 32'h0000_0100);
    base = n_logged;
    repeat (6) tick();
    check("post_flush_progress", 32'(n_logged - base >= 3), 32'd1);

    // Redirect with bubble and a response in the same cycle: one left to discard.
    mem_hold = 1'b1;
    repeat (4) tick();
    check("hold2_outstanding", 32'(mq.size()), 32'd2);
    E_jmp_sel_i = 1'b1;
    F_bubble_i = 1'b1;
    E_jmp_target_i = 32'h0000_0200;
    mem_hold = 1'b0;
    tick();
    check("jmpb_f_valid", 32'(F_valid_o), 32'd0);
    check("jmpb_f_instr", F_instr_o, 32'h0000_0013);
    check("jmpb_f_pc", F_pc_o, 32'd0);
    E_jmp_sel_i = 1'b0;
    F_bubble_i = 1'b0;
    exp_pc = 32'h0000_0200;
    tick();
    check("discard1_req", 32'(last_req), 32'd0);
    tick();
    check("discard1_done_req", 32'(last_req), 32'd1);
    check("discard1_done_addr", last_addr, 32'h0000_0200);
    repeat (6) tick();

    // Fetch at the top of the address space wraps to zero.
    E_jmp_sel_i = 1'b1;
    E_jmp_target_i = 32'hFFFF_FFFC;
    tick();
    E_jmp_sel_i = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    wait_req("wrap_first_addr", 32'hFFFF_FFFC);
    wait_req("wrap_next_addr", 32'h0000_0000);
    base = n_logged;
    repeat (6) tick();
    check("wrap_progress", 32'(n_logged - base >= 2), 32'd1);

    // Asynchronous reset with two requests in flight.
    mem_hold = 1'b1;
    repeat (4) tick();
    check("hold3_outstanding", 32'(mq.size()), 32'd2);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_f_valid", 32'(F_valid_o), 32'd0);
    check("arst_f_pc", F_pc_o, 32'd0);
    check("arst_f_instr", F_instr_o, NOP);
    check("arst_addr", imem_addr_o, RST_PC);
    mq.delete();
    mem_hold = 1'b0;
    imem_rvalid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    exp_pc = RST_PC;
    wait_req("restart_addr", RST_PC);
    base = n_logged;
    repeat (8) tick();
    check("restart_progress", 32'(n_logged - base >= 4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction presented on a bubble.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 PC_stall_i  in  1  hold PC, issue no new fetch request.
REQ-006 PC_bubble_i  in  1  suppress fetch request this cycle; PC held.
REQ-007 F_stall_i  in  1  hold F output register.
REQ-008 F_bubble_i  in  1  load NOP/invalid into F output register.
REQ-009 E_jmp_sel_i  in  1  redirect from execute, taken branch/jump.
REQ-010 E_jmp_target_i  in  32  redirect target address.
REQ-011 imem_req_o  out  1  instruction fetch request.
REQ-012 imem_addr_o  out  32  request address, equals PC.
REQ-013 imem_gnt_i  in  1  request accepted this cycle.
REQ-014 imem_rvalid_i  in  1  response valid, in request order.
REQ-015 imem_rdata_i  in  32  response instruction word.
REQ-016 F_pc_o  out  32  PC of instruction handed to decode.
REQ-017 F_instr_o  out  32  instruction handed to decode.
REQ-018 F_valid_o  out  1  F output holds a real instruction.
REQ-019 F_wait_o  out  1  decode needs an instruction and none is buffered.

Function
REQ-020 Outstanding-request counter (0..2) and 2-entry {pc,instr} FIFO; outstanding + FIFO count SHALL never exceed 2.
REQ-021 imem_req_o = RUN state & ~E_jmp_sel_i & ~PC_stall_i & ~PC_bubble_i & (outstanding + count < 2).
REQ-022 On imem_req_o & imem_gnt_i: PC <= PC+4 (mod 2^32 wrap), outstanding++; issued PC pushed to an internal 2-deep address tag queue.
REQ-023 On imem_rvalid_i with discard count 0: push {tag, rdata} to FIFO, outstanding--; same-cycle gnt and rvalid leave outstanding unchanged.
REQ-024 On imem_rvalid_i with discard count > 0: drop response, discard--, outstanding--.
REQ-025 Redirect (E_jmp_sel_i=1): PC <= E_jmp_target_i, FIFO and tag queue cleared, discard <= outstanding minus any rvalid this cycle; state -> FLUSH if result > 0 else RUN; overrides PC_stall_i.
REQ-026 FSM states RUN, FLUSH; FLUSH -> RUN when discard reaches 0; no requests in FLUSH; redirect in FLUSH accumulates discard.
REQ-027 F output update, priority order: F_stall_i holds; else E_jmp_sel_i or F_bubble_i loads {pc=0, NOP_INSTR, valid=0}; else FIFO non-empty pops head with valid=1; else loads NOP, valid=0.
REQ-028 Same-cycle FIFO push and pop SHALL be supported at count 0 (bypass not required; word appears next pop), 1 and 2.
REQ-029 F_wait_o = ~F_stall_i & ~E_jmp_sel_i & ~F_bubble_i & FIFO empty; combinational.
REQ-030 Minimum latency: response in cycle N appears on F outputs at edge N+1 when F not stalled.
REQ-031 Lost-response check: rvalid with outstanding 0 SHALL be ignored; assertion flags it in simulation.

Reset
REQ-032 On rst_n_i low: PC=RESET_PC, state RUN, outstanding=0, discard=0, FIFO/tag empty, F_valid_o=0, F_pc_o=0, F_instr_o=NOP_INSTR.
REQ-033 Reset mid-transaction abandons in-flight requests; memory side is reset in the same domain.
REQ-034 First request asserted in the first cycle after rst_n_i deasserts.

Structure
REQ-035 RESET_PC default, NOP_INSTR and FETCH_DEPTH (2) belong in shared define.v.
REQ-036 One sub-module fetch_fifo (2-entry, {pc,instr}, push/pop/flush, count); tag queue reuses it at width 32.

Verification
REQ-037 Zero-wait memory, no hazards: F_pc_o sequence RESET_PC, +4, +8, one per cycle, F_valid_o=1 from cycle 2.
REQ-038 F_stall_i high 3 cycles: outstanding+FIFO saturates at 2, imem_req_o drops, F outputs constant; on release no instruction lost or duplicated.
REQ-039 Redirect to 0x100 with 2 outstanding: both responses dropped, state FLUSH 2 cycles, next F_pc_o=0x100 valid, no stale instruction.
REQ-040 Redirect with F_bubble_i same cycle and rvalid same cycle: discard=1, F_valid_o=0 next cycle, F_instr_o=0x00000013.
REQ-041 PC=0xFFFF_FFFC fetch: next imem_addr_o=0x0000_0000.
REQ-042 rst_n_i asserted async while outstanding=2: outputs at reset values immediately; restart at RESET_PC.
